// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder in front of a word-organised single-port SRAM.
// Handles byte/halfword/word transfers, programmable wait states and the two-cycle ERROR response.
//
// state  | meaning
// IDLE   | no data phase pending, zero-wait OKAY
// ACTIVE | OKAY data phase, cnt counts remaining wait states
// ERR1   | first ERROR cycle, HREADYOUT low
// ERR2   | second ERROR cycle, next address phase may be accepted
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR1, ERR2} state_t;

  state_t                state, state_d;
  logic [2:0]            cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            offs;
  logic [1:0]            size_q;
  logic                  wr_q;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic                  valid;
  logic                  addr_err;
  logic                  accept;
  logic                  commit;
  logic [3:0]            lane_en;

  // Upper address bits alias the memory; HTRANS[0] only separates NONSEQ from SEQ.
  logic                  unused_inputs;
  assign unused_inputs = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign valid    = HSEL && HTRANS[1];
  assign addr_err = (HSIZE > 3'd2) ||
                    (HSIZE == 3'd1 && HADDR[0]) ||
                    (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      IDLE:   accept = HREADY;
      ACTIVE: begin
        HREADYOUT = (cnt == 3'd0);
        if (cnt != 3'd0) begin
          cnt_d = cnt - 3'd1;
        end else begin
          accept = HREADY;
          commit = HREADY && wr_q;
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ERR2;
      end
      ERR2: begin
        HRESP  = 1'b1;
        accept = HREADY;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (valid && addr_err) begin
        state_d = ERR1;
        cnt_d   = 3'd0;
      end else if (valid) begin
        state_d = ACTIVE;
        cnt_d   = 3'(WAIT_STATES);
      end else begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      idx    <= '0;
      offs   <= 2'b00;
      size_q <= 2'b00;
      wr_q   <= 1'b0;
    end else if (accept && valid) begin
      idx    <= HADDR[ADDR_WIDTH+1:2];
      offs   <= HADDR[1:0];
      size_q <= HSIZE[1:0];
      wr_q   <= HWRITE;
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'd0:    lane_en[offs] = 1'b1;
      2'd1:    lane_en = offs[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // A reset on the commit edge drops the pending write.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      for (int n = 0; n < 4; n++) begin
        if (lane_en[n]) mem[idx][8*n +: 8] <= HWDATA[8*n +: 8];
      end
    end
  end

  assign HRDATA = (state == ACTIVE && !wr_q) ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: three instances (0, 2, 3 wait states) on a shared bus,
// checked cycle by cycle against a byte-addressed memory model.
module tb_ahb_lite_sram_slave;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } xfer_t;

  localparam xfer_t IDLE_X = '{sel: 1'b0, trans: 2'b00, addr: 32'h0, size: 3'd0, wr: 1'b0, wdata: 32'h0};

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        hsel_bus = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'd0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'h0;
  logic        force_low = 1'b0;
  int          dut_sel = 0;

  logic [2:0]  hro, hresp, hready, hsel;
  logic [31:0] hrd0, hrd1, hrd2;

  int checks = 0;
  int failures = 0;

  xfer_t seq[$];
  logic [7:0] ref_mem [int];

  always #5 HCLK = ~HCLK;

  assign hready = hro & {3{~force_low}};
  assign hsel   = {dut_sel == 2 && hsel_bus, dut_sel == 1 && hsel_bus, dut_sel == 0 && hsel_bus};

  ahb_lite_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready[0]),
    .HREADYOUT(hro[0]), .HRESP(hresp[0]), .HRDATA(hrd0));

  ahb_lite_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready[1]),
    .HREADYOUT(hro[1]), .HRESP(hresp[1]), .HRDATA(hrd1));

  ahb_lite_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(hready[2]),
    .HREADYOUT(hro[2]), .HRESP(hresp[2]), .HRDATA(hrd2));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? hrd0 : (d == 1) ? hrd1 : hrd2;
  endfunction

  function automatic bit is_valid(input xfer_t x);
    return x.sel && x.trans[1];
  endfunction

  function automatic bit is_err(input xfer_t x);
    return (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'b00);
  endfunction

  // 16 KB window per instance; higher address bits alias.
  function automatic int key(input int d, input logic [31:0] a);
    return d * 16384 + int'(a % 32'd16384);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] base;
    w = 32'h0;
    base = a - (a % 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (ref_mem.exists(key(d, base + 32'(j)))) w[8*j +: 8] = ref_mem[key(d, base + 32'(j))];
    end
    return w;
  endfunction

  function automatic void model_write(input int d, input xfer_t x);
    int nb;
    logic [31:0] ba;
    nb = 1 << x.size;
    for (int j = 0; j < nb; j++) begin
      ba = x.addr + 32'(j);
      ref_mem[key(d, ba)] = x.wdata[8*int'(ba % 32'd4) +: 8];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                      input logic [2:0] size, input logic wr, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.addr = addr; x.size = size; x.wr = wr; x.wdata = wdata;
    seq.push_back(x);
  endtask

  // Runs seq back-to-back on instance d. Each address phase is held for the whole
  // expected data phase of the previous transfer, as a real master would.
  task automatic run(input int d);
    xfer_t prev;
    xfer_t cur;
    int n;
    logic exp_rdy, exp_resp;
    logic [31:0] exp_rd;
    prev = IDLE_X;
    for (int i = 0; i <= seq.size(); i++) begin
      cur = (i < seq.size()) ? seq[i] : IDLE_X;
      dut_sel = d; hsel_bus = cur.sel; HTRANS = cur.trans; HADDR = cur.addr;
      HSIZE = cur.size; HWRITE = cur.wr; HWDATA = prev.wdata;
      n = !is_valid(prev) ? 1 : is_err(prev) ? 2 : ws_of(d) + 1;
      for (int k = 0; k < n; k++) begin
        @(negedge HCLK);
        if (!is_valid(prev)) begin
          exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'h0;
        end else if (is_err(prev)) begin
          exp_rdy = (k == 1); exp_resp = 1'b1; exp_rd = 32'h0;
        end else begin
          exp_rdy = (k == n - 1); exp_resp = 1'b0;
          exp_rd = prev.wr ? 32'h0 : model_word(d, prev.addr);
        end
        chk($sformatf("d%0d.x%0d.c%0d.ready", d, i, k), 32'(hro[d]), 32'(exp_rdy));
        chk($sformatf("d%0d.x%0d.c%0d.resp", d, i, k), 32'(hresp[d]), 32'(exp_resp));
        chk($sformatf("d%0d.x%0d.c%0d.rdata", d, i, k), rdata_of(d), exp_rd);
        @(posedge HCLK); #1;
      end
      if (is_valid(prev) && !is_err(prev) && prev.wr) model_write(d, prev);
      prev = cur;
    end
    seq.delete();
  endtask

  task automatic idle_bus();
    hsel_bus = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  initial begin
    logic [31:0] a;

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst.d%0d.ready", d), 32'(hro[d]), 32'h1);
      chk($sformatf("rst.d%0d.resp", d), 32'(hresp[d]), 32'h0);
      chk($sformatf("rst.d%0d.rdata", d), rdata_of(d), 32'h0);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // back-to-back word write then read, zero wait states
    push(1, 2'b10, 32'h100, 3'd2, 1, 32'hDEADBEEF);
    push(1, 2'b10, 32'h100, 3'd2, 0, 32'h0);
    run(0);

    // byte lanes over a zeroed word
    push(1, 2'b10, 32'h200, 3'd2, 1, 32'h00000000);
    push(1, 2'b11, 32'h201, 3'd0, 1, 32'h00001100);
    push(1, 2'b11, 32'h203, 3'd0, 1, 32'h22000000);
    push(1, 2'b10, 32'h200, 3'd2, 0, 32'h0);
    push(1, 2'b10, 32'h202, 3'd1, 1, 32'hA5A50000);
    push(1, 2'b10, 32'h200, 3'd2, 0, 32'h0);
    run(0);

    // misaligned and oversized transfers must not touch memory
    push(1, 2'b10, 32'h102, 3'd2, 1, 32'h12345678);
    push(1, 2'b10, 32'h101, 3'd1, 1, 32'h55555555);
    push(1, 2'b10, 32'h104, 3'd3, 1, 32'h66666666);
    push(1, 2'b10, 32'h100, 3'd2, 0, 32'h0);
    run(0);
    push(1, 2'b10, 32'h103, 3'd2, 1, 32'h77777777);
    push(1, 2'b10, 32'h100, 3'd2, 0, 32'h0);
    run(2);

    // 3 wait states with the next address held over the stall
    push(1, 2'b10, 32'h040, 3'd2, 1, 32'h01020304);
    push(1, 2'b10, 32'h044, 3'd2, 1, 32'hA0B0C0D0);
    push(1, 2'b10, 32'h040, 3'd2, 0, 32'h0);
    push(1, 2'b11, 32'h044, 3'd2, 0, 32'h0);
    run(2);

    // HREADY held low by another slave: the presented write is ignored
    push(1, 2'b10, 32'h1C0, 3'd2, 1, 32'h0BADCAFE);
    run(0);
    dut_sel = 0; force_low = 1'b1; hsel_bus = 1'b1; HTRANS = 2'b10;
    HADDR = 32'h1C0; HSIZE = 3'd2; HWRITE = 1'b1; HWDATA = 32'hFFFFFFFF;
    @(negedge HCLK);
    chk("hrdylow.ready0", 32'(hro[0]), 32'h1);
    @(posedge HCLK); #1;
    force_low = 1'b0; idle_bus();
    @(negedge HCLK);
    chk("hrdylow.ready1", 32'(hro[0]), 32'h1);
    chk("hrdylow.resp1", 32'(hresp[0]), 32'h0);
    chk("hrdylow.rdata1", hrd0, 32'h0);
    @(posedge HCLK); #1;
    push(1, 2'b10, 32'h1C0, 3'd2, 0, 32'h0);
    run(0);

    // reset during a write's wait state drops the write
    push(1, 2'b10, 32'h180, 3'd2, 1, 32'hCAFEF00D);
    run(1);
    dut_sel = 1; hsel_bus = 1'b1; HTRANS = 2'b10; HADDR = 32'h180; HSIZE = 3'd2; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HWRITE = 1'b0; HWDATA = 32'h12345678; HRESET = 1'b1;
    @(negedge HCLK);
    chk("rstws.ready_before", 32'(hro[1]), 32'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b0; idle_bus();
    @(negedge HCLK);
    chk("rstws.ready", 32'(hro[1]), 32'h1);
    chk("rstws.resp", 32'(hresp[1]), 32'h0);
    chk("rstws.rdata", hrd1, 32'h0);
    @(posedge HCLK); #1;
    push(1, 2'b10, 32'h180, 3'd2, 0, 32'h0);
    run(1);

    // random traffic, including aliased addresses, idle/busy and errors
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) push(1, 2'b10, 32'h300 + 32'(4 * w), 3'd2, 1, $urandom);
      run(d);
      for (int t = 0; t < 40; t++) begin
        a = 32'h300 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 14);
        push($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), a, 3'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom);
      end
      run(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
